// File: rtl/midi_pkg.sv
// Shared types, byte-class constants and the MIDI message-length helper
// used by the MIDI transmit arbiter.
package midi_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    INSERT = 3'd2,
    PASS   = 3'd3,
    SYSEX  = 3'd4,
    DROP   = 3'd5
  } midi_state_e;

  localparam logic [7:0] ST_SYSEX = 8'hF0;
  localparam logic [7:0] ST_EOX   = 8'hF7;
  localparam logic [7:0] RT_MIN   = 8'hF8;

  // Total message length (status byte included) implied by a status byte.
  // Returns 0 for SysEx start (open-ended) and for data bytes.
  function automatic logic [1:0] midi_msg_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd0;
    case (status[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd3;
      4'hC, 4'hD:                   len = 2'd2;
      4'hF: begin
        case (status[3:0])
          4'h0:       len = 2'd0;
          4'h1, 4'h3: len = 2'd2;
          4'h2:       len = 2'd3;
          default:    len = 2'd1;
        endcase
      end
      default: len = 2'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/midi_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after the
// pointer, wrapping modulo NREQ. Produces one-hot, index and an any flag.
module midi_rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  localparam int SW = IW + 1;
  localparam logic [SW-1:0] NREQ_W = SW'(NREQ);

  logic [SW-1:0] sum_s;
  logic [IW-1:0] cand_s;

  // Scan candidates in rotating order; the first valid one wins.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    sum_s    = '0;
    cand_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum_s = {1'b0, ptr_i} + SW'(k);
      if (sum_s >= NREQ_W) begin
        sum_s = sum_s - NREQ_W;
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[IW-1:0];
      if (!any_o && valid_i[cand_s]) begin
        any_o            = 1'b1;
        onehot_o[cand_s] = 1'b1;
        idx_o            = cand_s;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/midi_tx_arbiter.sv
// Shares one MIDI UART transmitter among NREQ byte sources. Ownership is
// granted per complete MIDI message, running status is re-inserted when
// another source changed the status on the wire, and a stalled owner is
// released after TIMEOUT idle cycles.
module midi_tx_arbiter
  import midi_pkg::*;
#(
  parameter int          NREQ    = 2,
  parameter logic [19:0] TIMEOUT = 20'd171800
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [NREQ-1:0]   grant,
  output logic              abort
);

  localparam int IW = (NREQ > 2) ? 2 : 1;

  midi_state_e state_q, state_d;
  logic [NREQ-1:0]      grant_q, grant_d;
  logic [IW-1:0]        gidx_q, gidx_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [NREQ-1:0][7:0] rs_q, rs_d;
  logic [7:0]           wire_st_q, wire_st_d;
  logic [1:0]           rem_q, rem_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 abort_q, abort_d;
  logic [19:0]          tmo_q, tmo_d;

  logic [NREQ-1:0] pick_onehot_s;
  logic [IW-1:0]   pick_idx_s;
  logic            pick_any_s;
  logic [7:0]      head_s;
  logic            head_valid_s;
  logic [7:0]      rs_g_s;
  logic [1:0]      head_len_s;
  logic [1:0]      rs_len_s;
  logic            load_s;
  logic            xfer_s;
  logic            fwd_s;
  logic            consume_s;
  logic            release_s;

  midi_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .valid_i  (req_valid),
    .ptr_i    (rr_q),
    .onehot_o (pick_onehot_s),
    .idx_o    (pick_idx_s),
    .any_o    (pick_any_s)
  );

  assign load_s     = !tx_valid_q || tx_ready;
  assign xfer_s     = tx_valid_q && tx_ready;
  assign head_len_s = midi_msg_len(head_s);
  assign rs_len_s   = midi_msg_len(rs_g_s);

  // Select head byte, valid and running status of the granted requester.
  always_comb begin
    head_s       = 8'h00;
    head_valid_s = 1'b0;
    rs_g_s       = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx_q == IW'(i)) begin
        head_s       = req_data[8*i +: 8];
        head_valid_s = req_valid[i];
        rs_g_s       = rs_q[i];
      end else begin
        head_s = head_s;
      end
    end
  end

  // Arbiter next state, status bookkeeping, output register and timeout.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_d       = rr_q;
    rs_d       = rs_q;
    wire_st_d  = wire_st_q;
    rem_d      = rem_q;
    tx_valid_d = tx_valid_q && !tx_ready;
    tx_data_d  = tx_data_q;
    abort_d    = 1'b0;
    tmo_d      = 20'd0;
    fwd_s      = 1'b0;
    consume_s  = 1'b0;
    release_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          grant_d = pick_onehot_s;
          gidx_d  = pick_idx_s;
          state_d = DECODE;
        end else begin
          state_d = IDLE;
        end
      end
      DECODE: begin
        if (!head_valid_s) begin
          grant_d = '0;
          state_d = IDLE;
        end else if (head_s >= RT_MIN) begin
          // rem=0 marks a lone realtime message: it releases on its own byte.
          rem_d   = 2'd0;
          state_d = PASS;
        end else if (head_s == ST_SYSEX) begin
          state_d = SYSEX;
        end else if (head_s[7]) begin
          rem_d   = head_len_s;
          state_d = PASS;
        end else if (rs_g_s == 8'h00) begin
          state_d = DROP;
        end else if (rs_g_s == wire_st_q) begin
          rem_d   = rs_len_s - 2'd1;
          state_d = PASS;
        end else begin
          state_d = INSERT;
        end
      end
      INSERT: begin
        if (load_s) begin
          tx_valid_d = 1'b1;
          tx_data_d  = rs_g_s;
          wire_st_d  = rs_g_s;
          rem_d      = rs_len_s - 2'd1;
          state_d    = PASS;
        end else begin
          state_d = INSERT;
        end
      end
      PASS: begin
        if (load_s && head_valid_s) begin
          fwd_s     = 1'b1;
          consume_s = 1'b1;
          if (head_s >= RT_MIN) begin
            release_s = (rem_q == 2'd0);
          end else if (rem_q <= 2'd1) begin
            release_s = 1'b1;
          end else begin
            rem_d = rem_q - 2'd1;
          end
        end else begin
          state_d = PASS;
        end
      end
      SYSEX: begin
        if (load_s && head_valid_s) begin
          fwd_s     = 1'b1;
          consume_s = 1'b1;
          if (head_s == ST_EOX) begin
            release_s = 1'b1;
          end else if (head_s >= RT_MIN || head_s == ST_SYSEX || !head_s[7]) begin
            state_d = SYSEX;
          end else if (head_len_s <= 2'd1) begin
            // A nested status ends the SysEx and starts a new message.
            release_s = 1'b1;
          end else begin
            rem_d   = head_len_s - 2'd1;
            state_d = PASS;
          end
        end else begin
          state_d = SYSEX;
        end
      end
      DROP: begin
        consume_s = head_valid_s;
        grant_d   = '0;
        state_d   = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase

    if (fwd_s) begin
      tx_valid_d = 1'b1;
      tx_data_d  = head_s;
      if (head_s[7] && head_s < RT_MIN) begin
        if (head_s[7:4] != 4'hF) begin
          rs_d[gidx_q] = head_s;
          wire_st_d    = head_s;
        end else begin
          rs_d[gidx_q] = 8'h00;
          wire_st_d    = 8'h00;
        end
      end else begin
        wire_st_d = wire_st_d;
      end
    end else begin
      tx_data_d = tx_data_d;
    end

    if (state_q == PASS || state_q == SYSEX) begin
      if (xfer_s || consume_s) begin
        tmo_d = 20'd0;
      end else if (tmo_q == TIMEOUT - 20'd1) begin
        abort_d   = 1'b1;
        wire_st_d = 8'h00;
        release_s = 1'b1;
      end else begin
        tmo_d = tmo_q + 20'd1;
      end
    end else begin
      tmo_d = 20'd0;
    end

    if (release_s) begin
      grant_d = '0;
      state_d = IDLE;
      rr_d    = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
    end else begin
      rr_d = rr_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_q       <= '0;
      rs_q       <= '0;
      wire_st_q  <= 8'h00;
      rem_q      <= 2'd0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      abort_q    <= 1'b0;
      tmo_q      <= 20'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_q       <= rr_d;
      rs_q       <= rs_d;
      wire_st_q  <= wire_st_d;
      rem_q      <= rem_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      abort_q    <= abort_d;
      tmo_q      <= tmo_d;
    end
  end

  assign req_ready = consume_s ? grant_q : '0;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign grant     = grant_q;
  assign abort     = abort_q;

endmodule

// File: tb/tb_midi_tx_arbiter.sv
// Scoreboard bench for midi_tx_arbiter: source queues feed the requesters,
// expected wire bytes are queued when stimulus is issued and popped on
// every UART transfer.
module tb_midi_tx_arbiter;

  localparam int          NREQ = 2;
  localparam logic [19:0] TMO  = 20'd150;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [1:0]  grant;
  logic        abort;

  always #5 clk = ~clk;

  midi_tx_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant     (grant),
    .abort     (abort)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] src0[$];
  logic [7:0] src1[$];
  logic [7:0] exp_q[$];

  logic [1:0] rdy_seen = 2'b00;
  bit         rnd_rdy = 1'b0;
  logic       tx_rdy_val = 1'b1;
  bit         chk_gnt = 1'b0;
  int         cyc = 0;
  int         last_xfer = 0;
  int         abort_cnt = 0;
  int         abort_dist = 0;
  int         rdy0_cnt = 0;
  int         rdy1_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: scoreboard pops, hold checks, event counters.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      rdy_seen   = 2'b00;
      prev_stall = 1'b0;
    end else begin
      rdy_seen = req_ready;
      if (req_ready[0]) rdy0_cnt++;
      if (req_ready[1]) rdy1_cnt++;
      if (req_ready != 2'b00) chk_eq("ready_onehot", 32'($onehot(req_ready)), 32'd1);
      if (chk_gnt && req_ready != 2'b00) begin
        chk_eq("t1_ready", 32'(req_ready), 32'd1);
        chk_eq("t1_grant", 32'(grant), 32'd1);
      end
      if (prev_stall) begin
        chk_eq("hold_valid", 32'(tx_valid), 32'd1);
        chk_eq("hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (abort) begin
        abort_cnt++;
        abort_dist = cyc - last_xfer;
      end
      if (tx_valid && tx_ready) begin
        last_xfer = cyc;
        if (exp_q.size() == 0) chk_eq("tx_extra", 32'(exp_q.size()), 32'd1);
        else chk_eq("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  // Source FIFO model and UART ready driver.
  initial begin
    req_valid = 2'b00;
    req_data  = 16'h0000;
    tx_ready  = 1'b0;
    forever begin
      @(posedge clk);
      if (rdy_seen[0] && src0.size() > 0) void'(src0.pop_front());
      if (rdy_seen[1] && src1.size() > 0) void'(src1.pop_front());
      #1;
      req_valid[0]   = (src0.size() > 0);
      req_data[7:0]  = (src0.size() > 0) ? src0[0] : 8'h00;
      req_valid[1]   = (src1.size() > 0);
      req_data[15:8] = (src1.size() > 0) ? src1[0] : 8'h00;
      tx_ready       = rnd_rdy ? 1'($urandom_range(0, 1)) : tx_rdy_val;
    end
  end

  task automatic send(input int r, input int n, input logic [79:0] v);
    for (int k = 0; k < n; k++) begin
      logic [7:0] b;
      b = v[8*(n-1-k) +: 8];
      if (r == 0) src0.push_back(b);
      else src1.push_back(b);
    end
  endtask

  task automatic expect_tx(input int n, input logic [79:0] v);
    for (int k = 0; k < n; k++) begin
      logic [7:0] b;
      b = v[8*(n-1-k) +: 8];
      exp_q.push_back(b);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    src0.delete();
    src1.delete();
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #2;
    reset     = 1'b0;
    abort_cnt = 0;
    rdy0_cnt  = 0;
    rdy1_cnt  = 0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (t < 3000 && !(exp_q.size() == 0 && src0.size() == 0 && src1.size() == 0 &&
                         grant == 2'b00 && !tx_valid)) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk_eq({tag, "_drain"}, 32'(exp_q.size() + src0.size() + src1.size()), 32'd0);
    chk_eq({tag, "_grant_idle"}, 32'(grant), 32'd0);
  endtask

  task automatic wait_exp(input string tag);
    int t;
    t = 0;
    while (t < 500 && exp_q.size() != 0) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk_eq({tag, "_exp_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int bad;
    int win_ok;
    reset = 1'b1;

    // 1: single note-on, reset state first
    apply_reset();
    @(negedge clk);
    #1;
    chk_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk_eq("rst_tx_data", 32'(tx_data), 32'd0);
    chk_eq("rst_grant", 32'(grant), 32'd0);
    chk_eq("rst_abort", 32'(abort), 32'd0);
    chk_eq("rst_ready", 32'(req_ready), 32'd0);
    chk_gnt = 1'b1;
    send(0, 3, 80'h903C64);
    expect_tx(3, 80'h903C64);
    wait_idle("t1");
    chk_gnt = 1'b0;
    chk_eq("t1_rdy_cnt", 32'(rdy0_cnt), 32'd3);

    // 2: running status re-inserted after another source changed wire status
    apply_reset();
    rnd_rdy = 1'b1;
    send(0, 5, 80'h903C643E40);
    send(1, 3, 80'hB0077F);
    expect_tx(9, 80'h903C64B0077F903E40);
    wait_idle("t2");
    chk_eq("t2_rdy0_cnt", 32'(rdy0_cnt), 32'd5);
    chk_eq("t2_rdy1_cnt", 32'(rdy1_cnt), 32'd3);

    // 3: running status kept on the wire, no insertion
    apply_reset();
    send(0, 5, 80'h903C643E40);
    expect_tx(5, 80'h903C643E40);
    wait_idle("t3");
    chk_eq("t3_rdy0_cnt", 32'(rdy0_cnt), 32'd5);
    rnd_rdy = 1'b0;

    // 4: round-robin order, pointer returns to req0
    apply_reset();
    tx_rdy_val = 1'b1;
    send(0, 2, 80'hC005);
    send(1, 2, 80'hC106);
    expect_tx(4, 80'hC005C106);
    wait_idle("t4a");
    send(0, 2, 80'hC005);
    send(1, 2, 80'hC106);
    expect_tx(4, 80'hC005C106);
    wait_idle("t4b");

    // 5: stalled owner released by timeout, req1 then served
    apply_reset();
    send(0, 2, 80'h903C);
    send(1, 2, 80'hC106);
    expect_tx(4, 80'h903CC106);
    wait_idle("t5a");
    chk_eq("t5_abort_cnt", 32'(abort_cnt), 32'd1);
    win_ok = (abort_dist >= int'(TMO) && abort_dist <= int'(TMO) + 2) ? 1 : 0;
    chk_eq("t5_abort_timing", 32'(win_ok), 32'd1);
    send(0, 2, 80'h3E40);
    expect_tx(3, 80'h903E40);
    wait_idle("t5b");
    chk_eq("t5_abort_once", 32'(abort_cnt), 32'd1);

    // 6: SysEx with embedded realtime, then orphan data byte dropped
    apply_reset();
    send(0, 6, 80'hF04310F87FF7);
    expect_tx(6, 80'hF04310F87FF7);
    wait_idle("t6a");
    send(0, 1, 80'h11);
    wait_idle("t6b");
    chk_eq("t6_tx_valid", 32'(tx_valid), 32'd0);
    chk_eq("t6_rdy_cnt", 32'(rdy0_cnt), 32'd7);

    // 7: reset mid-message clears running status
    apply_reset();
    send(0, 2, 80'h903C);
    expect_tx(2, 80'h903C);
    wait_exp("t7a");
    apply_reset();
    @(negedge clk);
    #1;
    chk_eq("t7_tx_valid", 32'(tx_valid), 32'd0);
    chk_eq("t7_tx_data", 32'(tx_data), 32'd0);
    chk_eq("t7_grant", 32'(grant), 32'd0);
    send(0, 1, 80'h3C);
    wait_idle("t7b");
    chk_eq("t7_dropped", 32'(rdy0_cnt), 32'd1);
    chk_eq("t7_no_tx", 32'(tx_valid), 32'd0);

    // 8: UART backpressure for 100 cycles
    apply_reset();
    tx_rdy_val = 1'b0;
    send(0, 3, 80'h903C64);
    expect_tx(3, 80'h903C64);
    bad = 0;
    for (int t = 0; t < 50 && !tx_valid; t++) begin
      @(negedge clk);
      #1;
    end
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      #1;
      if (tx_valid !== 1'b1 || tx_data !== 8'h90 || req_ready !== 2'b00 || abort !== 1'b0) bad++;
    end
    chk_eq("t8_stall_stable", 32'(bad), 32'd0);
    chk_eq("t8_src_left", 32'(src0.size()), 32'd2);
    tx_rdy_val = 1'b1;
    wait_idle("t8");
    chk_eq("t8_abort_cnt", 32'(abort_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Global watchdog against a hung run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
